// File: rtl/mem_defs_pkg.sv
// Access-mode encodings and alignment rule shared by the RAM arbiter and its clients.
package mem_defs;
  localparam logic [2:0] MODE_WORD = 3'b100;
  localparam logic [2:0] MODE_HALF = 3'b010;
  localparam logic [2:0] MODE_BYTE = 3'b001;

  function automatic logic mode_aligned(input logic [2:0] mode, input logic [1:0] a);
    case (mode)
      MODE_WORD: return (a == 2'b00);
      MODE_HALF: return !a[0];
      MODE_BYTE: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive IF losses; at_max hands IF the next contended cycle.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);
  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_cnt <= '0;
    else if (i_clr)                     r_cnt <= '0;
    else if (i_inc && r_cnt != CW'(MAX)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_at_max = (r_cnt == CW'(MAX));
endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and load/store (D) with
// starvation guard, same-cycle RAM drive and one-cycle registered responses.
module ram_port_arbiter
  import mem_defs::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_STALL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_mode,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          ram_we,
  output logic [2:0]    ram_mode,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  logic w_at_max, w_if_win, w_d_win, w_if_legal, w_d_legal;

  arb_starve_counter #(.MAX(MAX_STALL)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (if_req && !w_if_win),
    .i_clr    (w_if_win),
    .o_at_max (w_at_max)
  );

  assign w_if_win   = if_req && (!d_req || w_at_max);
  assign w_d_win    = d_req && !w_if_win;
  assign w_if_legal = mode_aligned(MODE_WORD, if_addr[1:0]);
  assign w_d_legal  = mode_aligned(d_mode, d_addr[1:0]);
  assign if_gnt     = w_if_win;
  assign d_gnt      = w_d_win;

  // Illegal grants leave the RAM bus at its idle values so nothing is touched.
  always_comb begin
    ram_we      = 1'b0;
    ram_mode    = MODE_WORD;
    ram_address = '0;
    ram_wdata   = '0;
    if (w_if_win && w_if_legal) begin
      ram_address = if_addr;
    end else if (w_d_win && w_d_legal) begin
      ram_we      = d_we;
      ram_mode    = d_mode;
      ram_address = d_addr;
      ram_wdata   = d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= w_if_win;
      if_err    <= w_if_win && !w_if_legal;
      if_rdata  <= (w_if_win && w_if_legal) ? ram_rdata : '0;
      d_rvalid  <= w_d_win;
      d_err     <= w_d_win && !w_d_legal;
      d_rdata   <= (w_d_win && w_d_legal && !d_we) ? ram_rdata : '0;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a byte-lane RAM model behind it.
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]  d_mode;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        ram_we;
  logic [2:0]  ram_mode;
  logic [31:0] ram_address, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];

  ram_port_arbiter #(.AW(32), .DW(32), .MAX_STALL(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_we(ram_we), .ram_mode(ram_mode), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: little-endian, combinational read, zero-extended sub-word reads.
  always_comb begin
    logic [5:0] a;
    a = ram_address[5:0];
    ram_rdata = '0;
    case (ram_mode)
      3'b100: ram_rdata = {mem[{a[5:2],2'd3}], mem[{a[5:2],2'd2}], mem[{a[5:2],2'd1}], mem[{a[5:2],2'd0}]};
      3'b010: ram_rdata = {16'h0, mem[{a[5:1],1'b1}], mem[{a[5:1],1'b0}]};
      3'b001: ram_rdata = {24'h0, mem[a]};
      default: ram_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_mode)
        3'b100: begin
          mem[{ram_address[5:2],2'd0}] <= ram_wdata[7:0];
          mem[{ram_address[5:2],2'd1}] <= ram_wdata[15:8];
          mem[{ram_address[5:2],2'd2}] <= ram_wdata[23:16];
          mem[{ram_address[5:2],2'd3}] <= ram_wdata[31:24];
        end
        3'b010: begin
          mem[{ram_address[5:1],1'b0}] <= ram_wdata[7:0];
          mem[{ram_address[5:1],1'b1}] <= ram_wdata[15:8];
        end
        3'b001: mem[ram_address[5:0]] <= ram_wdata[7:0];
        default: ;
      endcase
    end
  end

  task automatic idle();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_mode = 3'b100; d_addr = '0; d_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic d_op(input logic we, input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wd);
    if_req = 1'b0; d_req = 1'b1; d_we = we; d_mode = mode; d_addr = addr; d_wdata = wd;
  endtask

  task automatic if_op(input logic [31:0] addr);
    d_req = 1'b0; if_req = 1'b1; if_addr = addr;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    d_req = 1'b1;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt_follows_req got=%b exp=1", d_gnt); end
    step();
    checks++; if ({if_rvalid, if_err, d_rvalid, d_err} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {if_rvalid, if_err, d_rvalid, d_err}); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
    idle(); #1;
    checks++; if ({ram_we, ram_mode, ram_address, ram_wdata} !== {1'b0, 3'b100, 64'h0}) begin errors++; $display("FAIL idle_bus got we=%b mode=%b a=%h wd=%h exp 0/100/0/0", ram_we, ram_mode, ram_address, ram_wdata); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_fetch();
    d_op(1'b1, 3'b100, 32'h0, 32'h87654321); #1;
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL st_gnt got d=%b if=%b exp d=1 if=0", d_gnt, if_gnt); end
    checks++; if (ram_we !== 1'b1 || ram_wdata !== 32'h87654321) begin errors++; $display("FAIL st_ram got we=%b wd=%h exp 1/87654321", ram_we, ram_wdata); end
    step();
    checks++; if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'h0) begin errors++; $display("FAIL st_resp got v/e=%b rd=%h exp 10/0", {d_rvalid, d_err}, d_rdata); end
    if_op(32'h0); #1;
    checks++; if (if_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL fetch_gnt got gnt=%b we=%b exp 1/0", if_gnt, ram_we); end
    step();
    checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h87654321) begin errors++; $display("FAIL fetch_data got v=%b e=%b rd=%h exp 1/0/87654321", if_rvalid, if_err, if_rdata); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL st_pulse got=%b exp=0", d_rvalid); end
    idle(); step();
  endtask

  task automatic test_starvation(input string tag);
    logic prev_if;
    prev_if = 1'bx;
    if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_mode = 3'b100; d_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      logic exp_if;
      exp_if = (i % 5 == 4);
      #1;
      checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin errors++; $display("FAIL %s_gnt cyc%0d got if=%b d=%b exp if=%b", tag, i, if_gnt, d_gnt, exp_if); end
      step();
      checks++; if (if_rvalid !== exp_if || d_rvalid !== !exp_if) begin errors++; $display("FAIL %s_rvalid cyc%0d got if=%b d=%b exp if=%b", tag, i, if_rvalid, d_rvalid, exp_if); end
      prev_if = exp_if;
    end
    idle(); step();
  endtask

  task automatic test_byte_merge();
    d_op(1'b1, 3'b100, 32'h0, 32'h98badcfe); step();
    for (int i = 1; i < 4; i++) begin
      d_op(1'b1, 3'b001, i, 32'h000000FE); #1;
      checks++; if (d_gnt !== 1'b1 || ram_mode !== 3'b001 || ram_we !== 1'b1) begin errors++; $display("FAIL byte_st%0d got gnt=%b mode=%b we=%b exp 1/001/1", i, d_gnt, ram_mode, ram_we); end
      step();
    end
    if_op(32'h0); step();
    checks++; if (if_rdata !== 32'hFEFEFEFE) begin errors++; $display("FAIL byte_merge got=%h exp=fefefefe", if_rdata); end
    idle(); step();
  endtask

  task automatic test_errors();
    d_op(1'b0, 3'b010, 32'h3, 32'h0); #1;
    checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL half_mis_gnt got gnt=%b we=%b exp 1/0", d_gnt, ram_we); end
    step();
    checks++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'h0) begin errors++; $display("FAIL half_mis_resp got v/e=%b rd=%h exp 11/0", {d_rvalid, d_err}, d_rdata); end
    d_op(1'b1, 3'b011, 32'h0, 32'hDEADBEEF); #1;
    checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL bad_mode_gnt got gnt=%b we=%b exp 1/0", d_gnt, ram_we); end
    step();
    checks++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'h0) begin errors++; $display("FAIL bad_mode_resp got v/e=%b rd=%h exp 11/0", {d_rvalid, d_err}, d_rdata); end
    if_op(32'h0); step();
    checks++; if (if_rdata !== 32'hFEFEFEFE) begin errors++; $display("FAIL bad_mode_nowrite got=%h exp=fefefefe", if_rdata); end
    d_op(1'b1, 3'b100, 32'h4, 32'h11223344); step();
    if_op(32'h2); #1;
    checks++; if (if_gnt !== 1'b1 || ram_address !== 32'h0 || ram_we !== 1'b0) begin errors++; $display("FAIL if_mis_bus got gnt=%b a=%h we=%b exp 1/0/0", if_gnt, ram_address, ram_we); end
    step();
    checks++; if ({if_rvalid, if_err} !== 2'b11 || if_rdata !== 32'h0) begin errors++; $display("FAIL if_mis_resp got v/e=%b rd=%h exp 11/0", {if_rvalid, if_err}, if_rdata); end
    if_op(32'h4); step();
    checks++; if ({if_rvalid, if_err} !== 2'b10 || if_rdata !== 32'h11223344) begin errors++; $display("FAIL if_ok_resp got v/e=%b rd=%h exp 10/11223344", {if_rvalid, if_err}, if_rdata); end
    idle(); step();
  endtask

  task automatic test_back_to_back();
    d_op(1'b0, 3'b100, 32'h0, 32'h0); step();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hFEFEFEFE) begin errors++; $display("FAIL b2b_0 got v=%b rd=%h exp 1/fefefefe", d_rvalid, d_rdata); end
    d_op(1'b0, 3'b010, 32'h6, 32'h0); step();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h00001122) begin errors++; $display("FAIL b2b_1 got v=%b rd=%h exp 1/00001122", d_rvalid, d_rdata); end
    d_op(1'b0, 3'b001, 32'h5, 32'h0); step();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h00000033) begin errors++; $display("FAIL b2b_2 got v=%b rd=%h exp 1/00000033", d_rvalid, d_rdata); end
    // Same-address IF read and D store: D wins, IF retries and sees the new word.
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b1; d_mode = 3'b100; d_addr = 32'h8; d_wdata = 32'hA5A5A5A5; #1;
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL order_gnt got d=%b if=%b exp 1/0", d_gnt, if_gnt); end
    step();
    d_req = 1'b0; step();
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL order_data got v=%b rd=%h exp 1/a5a5a5a5", if_rvalid, if_rdata); end
    idle(); step();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_mode = 3'b100; d_addr = 32'h0;
    step(); step(); step();
    rst = 1'b1; idle(); #1;
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_drop got if=%b d=%b exp 0/0", if_rvalid, d_rvalid); end
    step();
    rst = 1'b0; step();
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_after got if=%b d=%b exp 0/0", if_rvalid, d_rvalid); end
    test_starvation("midrst");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_store_fetch();
    test_starvation("starve");
    test_byte_merge();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
